// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM states, error codes, RV32I opcodes/funct3
// and the access-legality helpers used when an instruction is accepted.
package lsu_pkg;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} lsu_state_e;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'd0,
      ERR_MISALIGN = 2'd1,
      ERR_TIMEOUT  = 2'd2,
      ERR_FUNCT3   = 2'd3
   } lsu_err_e;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
      if (is_store) return f3 > F3_W;
      return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
   endfunction

   // Size lives in funct3[1:0] for both signed and unsigned loads.
   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
      case (f3[1:0])
         2'd1:    return lo[0];
         2'd2:    return lo != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering: store data replication / byte enables, and
// load data extraction with sign or zero extension.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] st_data_i,
   input  logic [31:0] rsp_data_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] ld_data_o
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   always_comb begin
      be_o    = 4'b1111;
      wdata_o = st_data_i;
      case (funct3_i[1:0])
         2'd0: begin
            be_o    = 4'b0001 << addr_lo_i;
            wdata_o = {4{st_data_i[7:0]}};
         end
         2'd1: begin
            be_o    = 4'b0011 << addr_lo_i;
            wdata_o = {2{st_data_i[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      case (addr_lo_i)
         2'd0:    ld_byte = rsp_data_i[7:0];
         2'd1:    ld_byte = rsp_data_i[15:8];
         2'd2:    ld_byte = rsp_data_i[23:16];
         default: ld_byte = rsp_data_i[31:24];
      endcase
      ld_half = addr_lo_i[1] ? rsp_data_i[31:16] : rsp_data_i[15:0];

      case (funct3_i)
         F3_B:    ld_data_o = {{24{ld_byte[7]}}, ld_byte};
         F3_H:    ld_data_o = {{16{ld_half[15]}}, ld_half};
         F3_BU:   ld_data_o = {24'd0, ld_byte};
         F3_HU:   ld_data_o = {16'd0, ld_half};
         default: ld_data_o = rsp_data_i;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: accepts one memory op from IDLE, issues a
// word-aligned request, waits for read data, and reports a one-cycle completion.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [6:0]        in_opcode,
   input  logic [2:0]        in_funct3,
   input  logic [31:0]       in_rs2_data,
   input  logic [ADDR_W-1:0] in_res,
   output logic              out_stall,
   output logic              out_valid,
   output logic [31:0]       out_mem_rd,
   output logic [1:0]        out_error,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_req_we,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic [31:0]       mem_req_wdata,
   output logic [3:0]        mem_req_be,
   input  logic              mem_rsp_valid,
   input  logic [31:0]       mem_rsp_data
);

   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

   lsu_state_e        state_q;
   lsu_err_e          err_q;
   logic              store_q;
   logic [2:0]        funct3_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       data_q;
   logic [15:0]       cnt_q;
   logic              req_valid_q;
   logic              valid_q;
   logic [31:0]       rd_q;

   logic        mem_op;
   logic        in_store;
   logic        timed_out;
   logic [31:0] ld_data;

   assign in_store  = (in_opcode == OP_STORE);
   assign mem_op    = in_valid && ((in_opcode == OP_LOAD) || in_store);
   // >= also covers a load whose handshake landed on the last allowed cycle.
   assign timed_out = (cnt_q >= TO_LAST);

   lsu_align u_align (
      .funct3_i   (funct3_q),
      .addr_lo_i  (addr_q[1:0]),
      .st_data_i  (data_q),
      .rsp_data_i (mem_rsp_data),
      .be_o       (mem_req_be),
      .wdata_o    (mem_req_wdata),
      .ld_data_o  (ld_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         err_q       <= ERR_NONE;
         store_q     <= 1'b0;
         funct3_q    <= 3'd0;
         addr_q      <= '0;
         data_q      <= 32'd0;
         cnt_q       <= 16'd0;
         req_valid_q <= 1'b0;
         valid_q     <= 1'b0;
         rd_q        <= 32'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (mem_op) begin
                  store_q  <= in_store;
                  funct3_q <= in_funct3;
                  addr_q   <= in_res;
                  data_q   <= in_rs2_data;
                  cnt_q    <= 16'd0;
                  rd_q     <= 32'd0;
                  if (f3_illegal(in_store, in_funct3)) begin
                     state_q <= S_DONE;
                     err_q   <= ERR_FUNCT3;
                     valid_q <= 1'b1;
                  end else if (misaligned(in_funct3, in_res[1:0])) begin
                     state_q <= S_DONE;
                     err_q   <= ERR_MISALIGN;
                     valid_q <= 1'b1;
                  end else begin
                     state_q     <= S_REQ;
                     req_valid_q <= 1'b1;
                  end
               end
            end
            S_REQ: begin
               cnt_q <= cnt_q + 16'd1;
               if (mem_req_ready) begin
                  req_valid_q <= 1'b0;
                  if (store_q) begin
                     state_q <= S_DONE;
                     err_q   <= ERR_NONE;
                     valid_q <= 1'b1;
                  end else begin
                     state_q <= S_WAIT;
                  end
               end else if (timed_out) begin
                  req_valid_q <= 1'b0;
                  state_q     <= S_DONE;
                  err_q       <= ERR_TIMEOUT;
                  valid_q     <= 1'b1;
               end
            end
            S_WAIT: begin
               cnt_q <= cnt_q + 16'd1;
               if (mem_rsp_valid) begin
                  rd_q    <= ld_data;
                  state_q <= S_DONE;
                  err_q   <= ERR_NONE;
                  valid_q <= 1'b1;
               end else if (timed_out) begin
                  state_q <= S_DONE;
                  err_q   <= ERR_TIMEOUT;
                  valid_q <= 1'b1;
               end
            end
            default: begin
               state_q <= S_IDLE;
               err_q   <= ERR_NONE;
               valid_q <= 1'b0;
               rd_q    <= 32'd0;
            end
         endcase
      end
   end

   assign out_stall     = ((state_q == S_IDLE) && mem_op) || (state_q == S_REQ) || (state_q == S_WAIT);
   assign out_valid     = valid_q;
   assign out_mem_rd    = rd_q;
   assign out_error     = err_q;
   assign mem_req_valid = req_valid_q;
   assign mem_req_we    = store_q;
   assign mem_req_addr  = {addr_q[ADDR_W-1:2], 2'b00};

endmodule
